// File: rtl/disp_arbiter.sv
// disp_arbiter: fixed-priority display arbiter with minimum-hold lock and
// 8-digit active-low seven-segment scan of the owner's 16-bit value.
module disp_arbiter #(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [7:0]  DIG,
  output logic [7:0]  Y
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;
  state_t          st_q, st_d;
  logic [DW-1:0]   div_q;
  logic [2:0]      idx_q;
  logic [1:0]      own_q, own_d, pick;
  logic [HW-1:0]   hold_q, hold_d, hold_inc;
  logic [15:0]     snap_q, snap_d, d_own, d_pick;
  logic [3:0]      grant_q, nib;
  logic            busy_q, tick, bnd, higher;
  logic [7:0]      dig_q, y_q, y_d;
  assign tick     = div_q == DW'(SCAN_DIV - 1);
  assign bnd      = tick && idx_q == 3'd7;
  assign pick     = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
  assign d_own    = own_q == 2'd0 ? data0 : own_q == 2'd1 ? data1 : own_q == 2'd2 ? data2 : data3;
  assign d_pick   = pick == 2'd0 ? data0 : pick == 2'd1 ? data1 : pick == 2'd2 ? data2 : data3;
  assign hold_inc = hold_q == HW'(HOLD_FRAMES) ? hold_q : hold_q + 1'b1;
  assign higher   = |(req & ((4'd1 << own_q) - 4'd1));
  always_comb begin
    st_d   = st_q;
    own_d  = own_q;
    hold_d = hold_q;
    snap_d = snap_q;
    if (bnd && st_q != OWN) begin
      st_d = |req ? OWN : IDLE;
      if (|req) begin
        own_d  = pick;
        hold_d = '0;
        snap_d = d_pick;
      end
    end else if (bnd) begin
      hold_d = hold_inc;
      if (hold_inc == HW'(HOLD_FRAMES)) begin
        if (!req[own_q]) st_d = |req ? BLANK : IDLE;
        else if (higher) st_d = BLANK;
        else snap_d = d_own;
      end
    end
  end
  // Each tick shows the slot just finished counting, using next-state data so
  // a boundary edge already reflects the new owner and snapshot.
  assign nib = snap_d[{idx_q[1:0], 2'b00} +: 4];
  assign y_d = st_d == IDLE  ? 8'hBF :
               st_d == BLANK ? 8'hFF :
               idx_q == 3'd7 ? HEX[{2'b00, own_d}] :
               idx_q[2]      ? 8'hFF : HEX[nib];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      idx_q   <= '0;
      st_q    <= IDLE;
      own_q   <= '0;
      hold_q  <= '0;
      snap_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      dig_q   <= 8'hFF;
      y_q     <= 8'hFF;
    end else begin
      div_q   <= tick ? '0 : div_q + 1'b1;
      st_q    <= st_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      grant_q <= st_d == OWN ? 4'd1 << own_d : 4'd0;
      busy_q  <= st_d != IDLE;
      if (tick) begin
        idx_q <= idx_q + 3'd1;
        dig_q <= ~(8'd1 << idx_q);
        y_q   <= y_d;
      end
    end
  end
  assign grant = grant_q;
  assign busy  = busy_q;
  assign DIG   = dig_q;
  assign Y     = y_q;
endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Arbiter and scan scheduler for the shared 8-digit seven-segment display. Four requesters (driven from switch inputs S1..S4 at top level) compete for the display. A fixed-priority arbiter with a minimum-hold lock decides which requester owns it. The block multiplexes the owner's 16-bit value onto the common-anode digit and segment lines, so it replaces the ad-hoc priority encoder and enable fan-out in front of the display driver.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥1.
- HOLD_FRAMES, 16: minimum full scan frames an owner keeps the display; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  4  request lines; req[0] has the highest priority and req[3] the lowest.
- data0..data3  in  16 each  value shown for requester 0..3.
- grant  out  4  one-hot current owner; 0 when no requester owns the display.
- busy  out  1  high in OWN and BLANK.
- DIG  out  8  digit select, active-low one-hot; DIG[0] is the rightmost digit.
- Y  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Divider: div_cnt counts 0..SCAN_DIV-1. A tick occurs when div_cnt==SCAN_DIV-1, and div_cnt returns to 0 on that cycle.
- Digit index: idx, 3 bits, increments on each tick and wraps 7→0. The tick that wraps idx is the frame boundary. One frame is 8×SCAN_DIV cycles.
- All state, grant, hold and snapshot updates happen only on frame-boundary edges.
- FSM states: IDLE, OWN, BLANK.
  - IDLE, at a boundary:
    - If req≠0: go to OWN. Owner = lowest set index of req. hold_cnt=0. Snapshot = that owner's data.
    - Otherwise stay in IDLE.
  - OWN, at a boundary: hold_cnt increments, saturating at HOLD_FRAMES.
    - If the new hold_cnt<HOLD_FRAMES: stay in OWN with the same owner, regardless of req.
    - Else, if req[owner]=0 and req=0: go to IDLE; grant becomes 0.
    - Else, if req[owner]=0, or any higher-priority req is set: go to BLANK; grant becomes 0.
    - Else: stay in OWN and refresh the snapshot from data[owner]. Lower-priority requests never preempt.
  - BLANK lasts exactly one frame. At its boundary:
    - If req≠0: go to OWN with the highest-priority current requester, hold_cnt=0, and a fresh snapshot.
    - Otherwise go to IDLE.
- Snapshot: a 16-bit register loaded only at boundaries. The display never tears mid-frame.
- Digit content while in OWN:
  - idx 3..0 show snapshot nibbles [15:12]..[3:0].
  - idx 7 shows the owner number 0..3 as hex.
  - idx 6..4 are blank (FF).
- IDLE: every digit shows a dash (Y=BF). BLANK: DIG keeps scanning, Y=FF.
- Hex encoding to Y (dp always off):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8.
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- DIG = ~(1<<idx).

## Timing
- Reset (rst=0, asynchronous): div_cnt=0, idx=0, state=IDLE, hold_cnt=0, snapshot=0, grant=0, busy=0, DIG=FF, Y=FF.
- After reset release:
  - DIG/Y are registered. They first drive digit 0 at the first tick edge, and update on every tick edge to reflect the new idx and state.
  - On a boundary edge, DIG/Y reflect the next state and snapshot on that same edge.
- grant and busy change only on boundary edges.
- Request latency: a req rising in IDLE is granted at the next boundary, worst case 8×SCAN_DIV cycles.
- req is sampled only on boundary cycles. Pulses shorter than a frame that miss a boundary are ignored.
- Simultaneous requests at a boundary: the lowest index wins.
- Owner drop with a simultaneous higher-priority request after the hold has expired: one BLANK frame, then the higher-priority requester.
- Reset asserted mid-frame or mid-hold: immediate return to the reset values. No partial frame completes.
- SCAN_DIV=1: a tick occurs every cycle, and the design must still be correct.

## Test plan
Use SCAN_DIV=2 and HOLD_FRAMES=2 (frame = 16 cycles) unless stated otherwise.
- Reset: hold rst=0 with random req and data. Required: DIG=FF, Y=FF, grant=0, busy=0. After release, the first tick drives DIG=FE, Y=BF, and all digits scan dashes.
- Single grant: req=0010, data1=0x3A5C, issued mid-frame. At the next boundary: grant=0010, busy=1. The next frame scans digit 7=F9 ("1"), digits 6..4=FF, and digits 3..0 = B0, 88, 92, C6.
- Hold lock: requester 2 owns the display and req0 rises in hold frame 1. grant stays 0100 through 2 frames, then one BLANK frame (Y=FF, grant=0), then grant=0001.
- No lower-priority preemption: req0 owns, req3 is also set, and both are held for 6 frames. grant stays 0001 throughout.
- Drop to idle: the owner drops req after the hold expires and no other req is set. grant=0 at the next boundary and dashes resume with no BLANK frame.
- Snapshot / reset mid-operation: change data0 mid-frame; the displayed nibbles change only from the next frame. Assert rst mid-frame; all outputs return to their reset values asynchronously, before the next clk edge.
